// File: rtl/mem_stage_if.sv
// Data-memory request/done bus between the memory stage and the data memory.
//   master (memory stage): mem_en, mem_wr, mem_addr, mem_wdata out; mem_rdata, mem_done in
//   slave  (data memory) : mirror of master
interface mem_stage_if #(
   parameter int AW = 16
);
   logic          mem_en;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [AW-1:0] mem_wdata;
   logic [AW-1:0] mem_rdata;
   logic          mem_done;

   modport master (
      output mem_en, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata, mem_done
   );

   modport slave (
      input  mem_en, mem_wr, mem_addr, mem_wdata,
      output mem_rdata, mem_done
   );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of the 16-bit pipelined core.
// Takes the execute result and store data, runs a variable-latency data
// memory access over the request/done bus, stalls upstream until it completes
// and presents registered write-back fields. Misaligned or read+write accesses
// park the stage in a sticky error state; HALT parks it in a sticky halt state.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   in_valid       instruction present from execute
//   ALUO           address for loads/stores, result value otherwise
//   st_data        store data
//   mem_read/mem_write/mem_to_reg/reg_write/wr_reg/halt  decoded controls
//   stall          upstream must hold this cycle
//   mem            data-memory bus (master side)
//   wb_valid/wb_data/wb_reg/wb_regwrite  registered write-back fields
//   halted, err    sticky status
//
// state  | meaning
// IDLE   | accepting instructions; ALU ops and HALT complete here
// BUSY   | memory request outstanding, waiting for mem_done
// ERR    | illegal memory access seen, stuck until reset
// HALTED | HALT executed, stuck until reset
module mem_stage #(
   parameter int AW = 16,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [AW-1:0] ALUO,
   input  logic [AW-1:0] st_data,
   input  logic          mem_read,
   input  logic          mem_write,
   input  logic          mem_to_reg,
   input  logic          reg_write,
   input  logic [RW-1:0] wr_reg,
   input  logic          halt,
   output logic          stall,
   mem_stage_if.master   mem,
   output logic          wb_valid,
   output logic [AW-1:0] wb_data,
   output logic [RW-1:0] wb_reg,
   output logic          wb_regwrite,
   output logic          halted,
   output logic          err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY   = 2'd1,
      S_ERR    = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic          memop;
   logic          bad_access;
   logic          alu_op;
   logic          accept_mem;
   logic          mem_wr_q;
   logic [AW-1:0] mem_addr_q;
   logic [AW-1:0] mem_wdata_q;
   logic [RW-1:0] cap_reg;
   logic          cap_regwrite;
   logic          cap_to_reg;

   assign memop      = mem_read | mem_write;
   assign bad_access = ALUO[0] | (mem_read & mem_write);
   // memop outranks halt: a HALT flagged with a memory op is treated as the op
   assign alu_op     = in_valid & ~memop & ~halt;
   assign accept_mem = in_valid & memop & ~bad_access;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               if (memop)     state_nxt = bad_access ? S_ERR : S_BUSY;
               else if (halt) state_nxt = S_HALTED;
            end
         end
         S_BUSY:   if (mem.mem_done) state_nxt = S_IDLE;
         default:  state_nxt = state;
      endcase
   end

   // mem_en is decoded from state so an async reset drops it immediately
   always_comb begin
      stall      = 1'b0;
      mem.mem_en = 1'b0;
      err        = 1'b0;
      halted     = 1'b0;
      case (state)
         S_IDLE:   stall = in_valid & memop;
         S_BUSY: begin
            mem.mem_en = 1'b1;
            stall      = ~mem.mem_done;
         end
         S_ERR: begin
            stall = 1'b1;
            err   = 1'b1;
         end
         S_HALTED: begin
            stall  = 1'b1;
            halted = 1'b1;
         end
         default:  stall = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cap_reg      <= '0;
         cap_regwrite <= 1'b0;
         cap_to_reg   <= 1'b0;
         wb_valid     <= 1'b0;
         wb_data      <= '0;
         wb_reg       <= '0;
         wb_regwrite  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               wb_valid <= alu_op;
               if (alu_op) begin
                  wb_data     <= ALUO;
                  wb_reg      <= wr_reg;
                  wb_regwrite <= reg_write;
               end
               if (accept_mem) begin
                  mem_addr_q   <= ALUO;
                  mem_wdata_q  <= st_data;
                  mem_wr_q     <= mem_write;
                  cap_reg      <= wr_reg;
                  cap_regwrite <= reg_write;
                  cap_to_reg   <= mem_to_reg;
               end
            end
            S_BUSY: begin
               wb_valid <= mem.mem_done;
               if (mem.mem_done) begin
                  // without mem_to_reg the captured address is written back (store with update)
                  wb_data     <= cap_to_reg ? mem.mem_rdata : mem_addr_q;
                  wb_reg      <= cap_reg;
                  wb_regwrite <= cap_regwrite;
               end
            end
            default: wb_valid <= 1'b0;
         endcase
      end
   end

   assign mem.mem_wr    = mem_wr_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
   localparam int AW = 16;
   localparam int RW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [AW-1:0] aluo;
   logic [AW-1:0] st_data;
   logic          mem_read;
   logic          mem_write;
   logic          mem_to_reg;
   logic          reg_write;
   logic [RW-1:0] wr_reg;
   logic          halt;
   logic          stall;
   logic          wb_valid;
   logic [AW-1:0] wb_data;
   logic [RW-1:0] wb_reg;
   logic          wb_regwrite;
   logic          halted;
   logic          err;

   int errors = 0;
   int checks = 0;

   mem_stage_if #(.AW(AW)) bus ();

   mem_stage #(.AW(AW), .RW(RW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .ALUO        (aluo),
      .st_data     (st_data),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_to_reg  (mem_to_reg),
      .reg_write   (reg_write),
      .wr_reg      (wr_reg),
      .halt        (halt),
      .stall       (stall),
      .mem         (bus.master),
      .wb_valid    (wb_valid),
      .wb_data     (wb_data),
      .wb_reg      (wb_reg),
      .wb_regwrite (wb_regwrite),
      .halted      (halted),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] sd,
                        input logic rd, input logic wr, input logic m2r, input logic rw,
                        input logic [2:0] wreg, input logic h);
      in_valid   = v;
      aluo       = a;
      st_data    = sd;
      mem_read   = rd;
      mem_write  = wr;
      mem_to_reg = m2r;
      reg_write  = rw;
      wr_reg     = wreg;
      halt       = h;
   endtask

   // Idle slot with random junk on the data inputs; in_valid low.
   task automatic drive_idle();
      drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".stall"}, stall, 0);
      chk({tag, ".mem_en"}, bus.mem_en, 0);
      chk({tag, ".mem_wr"}, bus.mem_wr, 0);
      chk({tag, ".mem_addr"}, bus.mem_addr, 0);
      chk({tag, ".mem_wdata"}, bus.mem_wdata, 0);
      chk({tag, ".wb_valid"}, wb_valid, 0);
      chk({tag, ".wb_data"}, wb_data, 0);
      chk({tag, ".wb_reg"}, wb_reg, 0);
      chk({tag, ".wb_regwrite"}, wb_regwrite, 0);
      chk({tag, ".halted"}, halted, 0);
      chk({tag, ".err"}, err, 0);
   endtask

   // Non-memory op: one-cycle latency, never stalls.
   task automatic run_alu(input string tag, input logic [15:0] a, input logic rw, input logic [2:0] wreg);
      drive(1'b1, a, 16'($urandom), 1'b0, 1'b0, 1'($urandom), rw, wreg, 1'b0);
      #1;
      chk({tag, ".stall"}, stall, 0);
      tick();
      drive_idle();
      chk({tag, ".wb_valid"}, wb_valid, 1);
      chk({tag, ".wb_data"}, wb_data, a);
      chk({tag, ".wb_reg"}, wb_reg, wreg);
      chk({tag, ".wb_regwrite"}, wb_regwrite, rw);
      #1;
      chk({tag, ".stall_after"}, stall, 0);
   endtask

   // Legal memory op answered by the memory on BUSY cycle 'lat' (1 = same cycle mem_en rises).
   task automatic run_mem(input string tag, input logic [15:0] a, input logic [15:0] sd,
                          input logic rd, input logic wr, input logic m2r, input logic rw,
                          input logic [2:0] wreg, input int lat, input logic [15:0] rdata);
      logic [15:0] exp_data;
      exp_data = m2r ? rdata : a;
      drive(1'b1, a, sd, rd, wr, m2r, rw, wreg, 1'b0);
      #1;
      chk({tag, ".stall_accept"}, stall, 1);
      chk({tag, ".mem_en_accept"}, bus.mem_en, 0);
      tick();
      drive_idle();
      for (int i = 1; i <= lat; i++) begin
         chk({tag, ".mem_en"}, bus.mem_en, 1);
         chk({tag, ".mem_addr"}, bus.mem_addr, a);
         chk({tag, ".mem_wr"}, bus.mem_wr, wr);
         if (wr) chk({tag, ".mem_wdata"}, bus.mem_wdata, sd);
         chk({tag, ".wb_valid_busy"}, wb_valid, 0);
         if (i == lat) begin
            bus.mem_done  = 1'b1;
            bus.mem_rdata = rdata;
         end else begin
            bus.mem_rdata = 16'($urandom);
         end
         #1;
         chk({tag, ".stall_busy"}, stall, (i == lat) ? 1'b0 : 1'b1);
         tick();
         bus.mem_done = 1'b0;
      end
      chk({tag, ".wb_valid"}, wb_valid, 1);
      chk({tag, ".wb_data"}, wb_data, exp_data);
      chk({tag, ".wb_reg"}, wb_reg, wreg);
      chk({tag, ".wb_regwrite"}, wb_regwrite, rw);
      chk({tag, ".mem_en_done"}, bus.mem_en, 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.mem_done  = 1'b0;
      bus.mem_rdata = '0;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      #2;
      check_all_zero("reset");
      #10 rst = 1'b0;
      tick();

      // Directed test-plan items
      run_alu("alu_pass", 16'h1234, 1'b1, 3'd3);
      run_mem("load3", 16'h0040, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 3, 16'hBEEF);
      run_mem("stu0", 16'h0102, 16'h00AA, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1, 16'h7777);

      // Idle slot: in_valid low gives no write-back
      drive_idle();
      tick();
      chk("idle.wb_valid", wb_valid, 0);

      // Randomized traffic against the op-level model in run_alu/run_mem
      for (int n = 0; n < 40; n++) begin
         int kind;
         logic [15:0] a;
         kind = $urandom_range(0, 3);
         a = 16'($urandom);
         case (kind)
            0: run_alu("rnd_alu", a, 1'($urandom), 3'($urandom));
            1: run_mem("rnd_load", a & 16'hFFFE, 16'($urandom), 1'b1, 1'b0, 1'($urandom),
                       1'($urandom), 3'($urandom), $urandom_range(1, 4), 16'($urandom));
            2: run_mem("rnd_store", a & 16'hFFFE, 16'($urandom), 1'b0, 1'b1, 1'b0,
                       1'($urandom), 3'($urandom), $urandom_range(1, 4), 16'($urandom));
            default: begin
               drive_idle();
               bus.mem_done = 1'($urandom);
               tick();
               bus.mem_done = 1'b0;
               chk("rnd_idle.wb_valid", wb_valid, 0);
            end
         endcase
      end

      // Reset in the middle of an access
      drive(1'b1, 16'h0200, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0);
      tick();
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      chk("rst_mid.mem_en_before", bus.mem_en, 1);
      #2 rst = 1'b1;
      #1;
      check_all_zero("rst_mid");
      #2 rst = 1'b0;
      bus.mem_done  = 1'b1;
      bus.mem_rdata = 16'hDEAD;
      tick();
      bus.mem_done = 1'b0;
      chk("rst_mid.wb_valid_after", wb_valid, 0);
      chk("rst_mid.mem_en_after", bus.mem_en, 0);
      tick();
      chk("rst_mid.wb_valid_after2", wb_valid, 0);
      run_alu("rst_mid.alu", 16'h4321, 1'b1, 3'd1);

      // Misaligned store: sticky error
      drive(1'b1, 16'h0103, 16'h00AA, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
      #1;
      chk("misalign.stall_accept", stall, 1);
      chk("misalign.mem_en_accept", bus.mem_en, 0);
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 3'($urandom), 1'b0);
         bus.mem_done = 1'($urandom);
         #1;
         chk("misalign.err", err, 1);
         chk("misalign.stall", stall, 1);
         chk("misalign.mem_en", bus.mem_en, 0);
         chk("misalign.wb_valid", wb_valid, 0);
         tick();
      end
      bus.mem_done = 1'b0;

      // Read and write together is also illegal
      rst = 1'b1;
      #2 rst = 1'b0;
      drive(1'b1, 16'h0010, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0);
      tick();
      drive_idle();
      chk("rdwr.err", err, 1);
      chk("rdwr.mem_en", bus.mem_en, 0);

      // Halt: sticky, no further write-backs
      rst = 1'b1;
      #2 rst = 1'b0;
      chk("halt.err_cleared", err, 0);
      drive(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1);
      #1;
      chk("halt.stall_accept", stall, 0);
      tick();
      chk("halt.halted", halted, 1);
      chk("halt.wb_valid", wb_valid, 0);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 16'($urandom) & 16'hFFFE, 16'($urandom), 1'b0, 1'($urandom),
               1'b0, 1'b1, 3'($urandom), 1'b0);
         bus.mem_done = 1'($urandom);
         #1;
         chk("halt.stall", stall, 1);
         chk("halt.mem_en", bus.mem_en, 0);
         tick();
         chk("halt.halted_hold", halted, 1);
         chk("halt.wb_valid_hold", wb_valid, 0);
      end
      bus.mem_done = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
